// File: rtl/knn_stream_engine_if.sv
// Bus bundle for the streaming KNN engine: control, training-beat handshake and results.
interface knn_stream_engine_if #(
    parameter int DATA_W      = 8,
    parameter int DIM         = 2,
    parameter int N_NEIGHBOUR = 10,
    parameter int LABEL_W     = 8
);
    localparam int DIST_W = 2*DATA_W + 2 + $clog2(DIM);
    localparam int CNT_W  = $clog2(N_NEIGHBOUR + 1);

    logic                          start;
    logic [DIM*DATA_W-1:0]         test_coord;
    logic                          train_valid;
    logic                          train_ready;
    logic [DIM*DATA_W-1:0]         train_coord;
    logic [LABEL_W-1:0]            train_label;
    logic                          train_last;
    logic                          busy;
    logic                          done;
    logic [CNT_W-1:0]              nb_count;
    logic [N_NEIGHBOUR*DIST_W-1:0] nb_dist;
    logic [N_NEIGHBOUR*LABEL_W-1:0] nb_label;
    logic [LABEL_W-1:0]            vote_label;

    // Host / register-file side
    modport master (
        output start, test_coord, train_valid, train_coord, train_label, train_last,
        input  train_ready, busy, done, nb_count, nb_dist, nb_label, vote_label
    );

    // Engine side
    modport slave (
        input  start, test_coord, train_valid, train_coord, train_label, train_last,
        output train_ready, busy, done, nb_count, nb_dist, nb_label, vote_label
    );
endinterface

// File: rtl/knn_stream_engine.sv
// Streaming k-nearest-neighbour engine: squared-distance pipeline feeding a sorted
// insertion list, followed by a sequential majority vote over the list labels.
module knn_stream_engine #(
    parameter int DATA_W      = 8,
    parameter int DIM         = 2,
    parameter int N_NEIGHBOUR = 10,
    parameter int LABEL_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    knn_stream_engine_if.slave bus
);
    localparam int DIST_W = 2*DATA_W + 2 + $clog2(DIM);
    localparam int SQ_W   = 2*DATA_W + 2;
    localparam int CNT_W  = $clog2(N_NEIGHBOUR + 1);
    localparam int N      = N_NEIGHBOUR;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_VOTE  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                    state_q, state_d;
    logic [1:0]                    drain_q;
    logic [DIM*DATA_W-1:0]         test_q;
    logic                          accept;
    logic                          start_ok;

    // pipeline: [0] captured beat, [1] squares, [2] summed distance
    logic [2:0]                    vld_pipe_q;
    logic [DIM*DATA_W-1:0]         s0_coord_q;
    logic [LABEL_W-1:0]            s0_lbl_q, s1_lbl_q, s2_lbl_q;
    logic [DIM-1:0][SQ_W-1:0]      s1_sq_q, sq_d;
    logic [DIST_W-1:0]             s2_dist_q, sum_d;
    logic signed [DATA_W:0]        diff;
    logic signed [SQ_W-1:0]        dext;

    logic [N-1:0][DIST_W-1:0]      dist_q, ins_dist;
    logic [N-1:0][LABEL_W-1:0]     lbl_q, ins_lbl;
    logic [N-1:0]                  le;
    logic [CNT_W-1:0]              cnt_q;

    logic [CNT_W-1:0]              vidx_q, best_cnt_q, vcnt;
    logic [LABEL_W-1:0]            best_lbl_q, vote_q, cur_lbl;
    logic                          cur_valid;

    assign accept   = (state_q == S_RUN) && bus.train_valid;
    assign start_ok = (state_q == S_IDLE) && bus.start;

    // Next-state logic; VOTE holds one extra cycle after the last iteration to publish the result
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (accept && bus.train_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == 2'd2) state_d = S_VOTE;
            S_VOTE:  if (vidx_q == CNT_W'(N)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and drain counter (three cycles flush the pipeline)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
        end
    end

    // S1 math: per-dim difference in DATA_W+1 bits, squared exactly
    always_comb begin
        diff = '0;
        dext = '0;
        sq_d = '0;
        for (int d = 0; d < DIM; d++) begin
            diff = $signed({test_q[d*DATA_W+DATA_W-1], test_q[d*DATA_W +: DATA_W]})
                 - $signed({s0_coord_q[d*DATA_W+DATA_W-1], s0_coord_q[d*DATA_W +: DATA_W]});
            dext = SQ_W'(diff);
            sq_d[d] = SQ_W'(dext * dext);
        end
    end

    // S2 math: sum of squares
    always_comb begin
        sum_d = '0;
        for (int d = 0; d < DIM; d++) sum_d = sum_d + DIST_W'(s1_sq_q[d]);
    end

    // Distance pipeline registers; valid bits shift alongside the data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
            s0_coord_q <= '0;
            s0_lbl_q   <= '0;
            s1_sq_q    <= '0;
            s1_lbl_q   <= '0;
            s2_dist_q  <= '0;
            s2_lbl_q   <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], accept};
            s0_coord_q <= bus.train_coord;
            s0_lbl_q   <= bus.train_label;
            s1_sq_q    <= sq_d;
            s1_lbl_q   <= s0_lbl_q;
            s2_dist_q  <= sum_d;
            s2_lbl_q   <= s1_lbl_q;
        end
    end

    // S3 insert: le marks the sorted prefix with dist <= new; new goes right after it.
    // A full list with every entry <= new keeps everything, i.e. the beat is discarded.
    always_comb begin
        for (int j = 0; j < N; j++) le[j] = (CNT_W'(j) < cnt_q) && (dist_q[j] <= s2_dist_q);
        ins_dist[0] = le[0] ? dist_q[0] : s2_dist_q;
        ins_lbl[0]  = le[0] ? lbl_q[0]  : s2_lbl_q;
        for (int j = 1; j < N; j++) begin
            ins_dist[j] = le[j] ? dist_q[j] : (le[j-1] ? s2_dist_q : dist_q[j-1]);
            ins_lbl[j]  = le[j] ? lbl_q[j]  : (le[j-1] ? s2_lbl_q  : lbl_q[j-1]);
        end
    end

    // Neighbour list: cleared on accepted start, updated by each beat leaving S2
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dist_q <= '1;
            lbl_q  <= '0;
            cnt_q  <= '0;
            test_q <= '0;
        end else if (start_ok) begin
            dist_q <= '1;
            lbl_q  <= '0;
            cnt_q  <= '0;
            test_q <= bus.test_coord;
        end else if (vld_pipe_q[2]) begin
            dist_q <= ins_dist;
            lbl_q  <= ins_lbl;
            if (cnt_q != CNT_W'(N)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Vote iteration: label under the index and how many valid entries share it
    always_comb begin
        cur_lbl = '0;
        vcnt    = '0;
        for (int i = 0; i < N; i++) if (CNT_W'(i) == vidx_q) cur_lbl = lbl_q[i];
        for (int j = 0; j < N; j++)
            if ((CNT_W'(j) < cnt_q) && (lbl_q[j] == cur_lbl)) vcnt = vcnt + CNT_W'(1);
    end
    assign cur_valid = vidx_q < cnt_q;

    // Running best replaced only on a strictly larger count, so ties favour nearer entries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vidx_q     <= '0;
            best_cnt_q <= '0;
            best_lbl_q <= '0;
            vote_q     <= '0;
        end else if (state_q != S_VOTE) begin
            vidx_q     <= '0;
            best_cnt_q <= '0;
            best_lbl_q <= '0;
        end else if (vidx_q != CNT_W'(N)) begin
            vidx_q <= vidx_q + CNT_W'(1);
            if (cur_valid && (vcnt > best_cnt_q)) begin
                best_cnt_q <= vcnt;
                best_lbl_q <= cur_lbl;
            end
        end else begin
            vote_q <= best_lbl_q;
        end
    end

    assign bus.train_ready = (state_q == S_RUN);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.nb_count    = cnt_q;
    assign bus.nb_dist     = dist_q;
    assign bus.nb_label    = lbl_q;
    assign bus.vote_label  = vote_q;
endmodule

// File: tb/tb_knn_stream_engine.sv
// Directed bench for knn_stream_engine (DATA_W=8, DIM=2, N=3): table-driven beats with
// hand-computed list contents, plus reset, backpressure and start-while-busy sequences.
module tb_knn_stream_engine;
    localparam int DATA_W = 8;
    localparam int DIM    = 2;
    localparam int N      = 3;
    localparam int LW     = 8;
    localparam int DW     = 2*DATA_W + 2 + $clog2(DIM);
    localparam int ONES   = (1 << DW) - 1;

    typedef struct {
        bit first;
        int tx, ty;
        int x, y, lbl;
        bit last;
        int d0, d1, d2;
        int l0, l1, l2;
        int cnt;
        int vote;
    } vec_t;

    logic clk = 0;
    logic rst_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[13];

    knn_stream_engine_if #(.DATA_W(DATA_W), .DIM(DIM), .N_NEIGHBOUR(N), .LABEL_W(LW)) bus();

    knn_stream_engine #(.DATA_W(DATA_W), .DIM(DIM), .N_NEIGHBOUR(N), .LABEL_W(LW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int nb_d(input int k);
        return int'(bus.nb_dist[k*DW +: DW]);
    endfunction

    function automatic int nb_l(input int k);
        return int'(bus.nb_label[k*LW +: LW]);
    endfunction

    task automatic chk_list(input string tag, input int d0, d1, d2, l0, l1, l2, cnt);
        chk({tag, ".cnt"}, bus.nb_count, cnt);
        chk({tag, ".d0"}, nb_d(0), d0);
        chk({tag, ".d1"}, nb_d(1), d1);
        chk({tag, ".d2"}, nb_d(2), d2);
        chk({tag, ".l0"}, nb_l(0), l0);
        chk({tag, ".l1"}, nb_l(1), l1);
        chk({tag, ".l2"}, nb_l(2), l2);
    endtask

    task automatic do_start(input int tx, input int ty);
        int guard = 0;
        while (bus.busy && guard < 200) begin tick(); guard++; end
        chk("start_idle_timeout", guard, guard < 200 ? guard : 0);
        bus.test_coord = {8'(ty), 8'(tx)};
        bus.start = 1;
        tick();
        bus.start = 0;
        chk("start.ready", bus.train_ready, 1);
        chk("start.busy", bus.busy, 1);
        chk("start.cnt", bus.nb_count, 0);
        chk("start.d0_clear", nb_d(0), ONES);
    endtask

    task automatic send_beat(input int x, input int y, input int lbl, input bit last);
        int guard = 0;
        bus.train_valid = 1;
        bus.train_coord = {8'(y), 8'(x)};
        bus.train_label = 8'(lbl);
        bus.train_last  = last;
        while (!bus.train_ready && guard < 100) begin tick(); guard++; end
        if (guard >= 100) begin
            n_chk++; n_fail++;
            $display("FAIL beat_ready_timeout: got ready 0 expected 1");
        end
        tick();
        bus.train_valid = 0;
        bus.train_last  = 0;
    endtask

    // Called right after the last beat's acceptance edge t.
    task automatic last_checks(input string tag, input int d0, d1, d2, l0, l1, l2,
                               input int cnt, input int vote, input bit poke);
        int bad = 0;
        chk({tag, ".drain_ready"}, bus.train_ready, 0);
        for (int k = 1; k <= 3; k++) begin
            if (poke && k == 1) begin
                bus.start = 1;
                bus.test_coord = 16'h7F7F;
                bus.train_valid = 1;
                bus.train_coord = 16'h0000;
                bus.train_label = 8'h55;
            end
            tick();
            bus.start = 0;
            bus.train_valid = 0;
            if (bus.train_ready || bus.done) bad++;
        end
        chk_list({tag, ".final"}, d0, d1, d2, l0, l1, l2, cnt);
        for (int k = 4; k <= N + 3; k++) begin
            tick();
            if (bus.train_ready || bus.done || !bus.busy) bad++;
        end
        chk({tag, ".early_done_or_ready"}, bad, 0);
        tick();
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".done_busy"}, bus.busy, 1);
        chk({tag, ".vote"}, bus.vote_label, vote);
        tick();
        chk({tag, ".idle_busy"}, bus.busy, 0);
        chk({tag, ".done_pulse"}, bus.done, 0);
        chk({tag, ".hold_cnt"}, bus.nb_count, cnt);
        chk({tag, ".hold_vote"}, bus.vote_label, vote);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        string tag;
        v = tbl[i];
        tag = $sformatf("vec%0d", i);
        if (v.first) do_start(v.tx, v.ty);
        send_beat(v.x, v.y, v.lbl, v.last);
        if (!v.last) begin
            repeat (3) tick();
            chk_list(tag, v.d0, v.d1, v.d2, v.l0, v.l1, v.l2, v.cnt);
        end else begin
            last_checks(tag, v.d0, v.d1, v.d2, v.l0, v.l1, v.l2, v.cnt, v.vote, 0);
        end
    endtask

    initial begin
        int md[N];
        int ml[N];
        int mc, mv, best, tx, ty, x, y, l, d, pos, c, bad;

        //           first tx    ty    x    y    lbl last d0      d1      d2      l0 l1 l2 cnt vote
        tbl[0]  = '{1,    0,    0,    3,   4,   1,  0,   25,     ONES,   ONES,   1, 0, 0, 1,  0};
        tbl[1]  = '{0,    0,    0,    1,   1,   2,  0,   2,      25,     ONES,   2, 1, 0, 2,  0};
        tbl[2]  = '{0,    0,    0,   -2,   0,   1,  0,   2,      4,      25,     2, 1, 1, 3,  0};
        tbl[3]  = '{0,    0,    0,    5,   5,   3,  0,   2,      4,      25,     2, 1, 1, 3,  0};
        tbl[4]  = '{0,    0,    0,    0,   2,   1,  1,   2,      4,      4,      2, 1, 1, 3,  1};
        tbl[5]  = '{1,    0,    0,    3,   0,   5,  0,   9,      ONES,   ONES,   5, 0, 0, 1,  0};
        tbl[6]  = '{0,    0,    0,    1,   0,   7,  1,   1,      9,      ONES,   7, 5, 0, 2,  7};
        tbl[7]  = '{1, -128, -128,  127, 127,   9,  0,   130050, ONES,   ONES,   9, 0, 0, 1,  0};
        tbl[8]  = '{0, -128, -128,  127, 127,   4,  0,   130050, 130050, ONES,   9, 4, 0, 2,  0};
        tbl[9]  = '{0, -128, -128,  127, 127,   6,  0,   130050, 130050, 130050, 9, 4, 6, 3,  0};
        tbl[10] = '{0, -128, -128,  127, 127,   8,  1,   130050, 130050, 130050, 9, 4, 6, 3,  9};
        tbl[11] = '{1,    1,    1,    2,   3,   4,  0,   5,      ONES,   ONES,   4, 0, 0, 1,  0};
        tbl[12] = '{0,    1,    1,    1,   1,   2,  1,   0,      5,      ONES,   2, 4, 0, 2,  2};

        bus.start = 0; bus.test_coord = '0; bus.train_valid = 0;
        bus.train_coord = '0; bus.train_label = '0; bus.train_last = 0;

        // reset state
        rst_n = 0;
        tick(); tick();
        chk("rst.ready", bus.train_ready, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.vote", bus.vote_label, 0);
        chk_list("rst", ONES, ONES, ONES, 0, 0, 0, 0);
        rst_n = 1;
        tick();

        // basic sort, underfill, extremes
        for (int i = 0; i <= 10; i++) run_vec(i);

        // reset mid-run with beats still in the pipeline
        do_start(0, 0);
        send_beat(1, 0, 3, 0);
        send_beat(2, 0, 3, 0);
        send_beat(3, 0, 3, 0);
        send_beat(0, 1, 3, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst.ready", bus.train_ready, 0);
        chk("midrst.busy", bus.busy, 0);
        chk("midrst.done", bus.done, 0);
        chk("midrst.vote", bus.vote_label, 0);
        chk_list("midrst", ONES, ONES, ONES, 0, 0, 0, 0);
        bad = 0;
        repeat (6) begin
            tick();
            if (bus.done || bus.busy || bus.nb_count != 0) bad++;
        end
        chk("midrst.quiet", bad, 0);
        for (int i = 11; i <= 12; i++) run_vec(i);

        // randomly gated stream against a software model, start poked while busy
        tx = int'($urandom_range(255)) - 128;
        ty = int'($urandom_range(255)) - 128;
        for (int k = 0; k < N; k++) begin md[k] = ONES; ml[k] = 0; end
        mc = 0;
        do_start(tx, ty);
        for (int b = 0; b < 20; b++) begin
            repeat (int'($urandom_range(2))) tick();
            x = int'($urandom_range(255)) - 128;
            y = int'($urandom_range(255)) - 128;
            l = int'($urandom_range(3));
            d = (tx - x) * (tx - x) + (ty - y) * (ty - y);
            pos = 0;
            while (pos < mc && md[pos] <= d) pos++;
            if (pos < N) begin
                for (int k = N - 1; k > pos; k--) begin md[k] = md[k-1]; ml[k] = ml[k-1]; end
                md[pos] = d;
                ml[pos] = l;
                if (mc < N) mc++;
            end
            send_beat(x, y, l, b == 19);
        end
        mv = 0; best = 0;
        for (int i = 0; i < mc; i++) begin
            c = 0;
            for (int j = 0; j < mc; j++) if (ml[j] == ml[i]) c++;
            if (c > best) begin best = c; mv = ml[i]; end
        end
        last_checks("rand", md[0], md[1], md[2], ml[0], ml[1], ml[2], mc, mv, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
